// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between IF and MA with one outstanding
//            transaction, MA priority bounded by an IF starvation limit,
//            store lane formatting and discard of killed fetch responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int unsigned MAX_MA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_i,
  // instruction fetch
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_kill_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  // memory access stage
  input  logic        ma_req_i,
  input  logic        ma_we_i,
  input  logic [31:0] ma_addr_i,
  input  logic [31:0] ma_wdata_i,
  input  logic [1:0]  ma_size_i,
  output logic        ma_gnt_o,
  output logic        ma_rvalid_o,
  output logic [31:0] ma_rdata_o,
  // shared memory port
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_MA = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_MA_STREAK);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  logic [1:0]  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        kill_pend_q, kill_pend_d;

  logic        if_starved;
  logic        ma_sel;
  logic        any_req;
  logic        idle_act;
  logic        launch;
  logic        if_grant;
  logic        ma_grant;
  logic        rsp_if;
  logic        rsp_ma;
  logic        kill_now;

  logic [3:0]  ma_be;
  logic [31:0] ma_wdata_lanes;

  // Fetch address is always word-aligned on the port; the low bits are dropped.
  logic        unused_if_addr_lo;
  assign unused_if_addr_lo = ^if_addr_i[1:0];

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  assign if_starved = if_req_i && (streak_q == STREAK_MAX);
  assign ma_sel     = ma_req_i && !if_starved;
  assign any_req    = if_req_i || ma_req_i;
  assign idle_act   = (state_q == S_IDLE) && !rst_i;
  assign launch     = idle_act && any_req && mem_gnt_i;
  assign ma_grant   = launch && ma_sel;
  assign if_grant   = launch && !ma_sel;

  assign rsp_if     = (state_q == S_BUSY_IF) && mem_rvalid_i && !rst_i;
  assign rsp_ma     = (state_q == S_BUSY_MA) && mem_rvalid_i && !rst_i;

  // A redirect coinciding with the response also discards it: the fetch is stale.
  assign kill_now   = kill_pend_q || if_kill_i;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ma_grant) begin
          state_d = S_BUSY_MA;
        end else if (if_grant) begin
          state_d = S_BUSY_IF;
        end
      end
      S_BUSY_IF: begin
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY_MA: begin
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req_o   = 1'b0;
    if_gnt_o    = 1'b0;
    ma_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    ma_rvalid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_req_o = idle_act && any_req;
        if_gnt_o  = if_grant;
        ma_gnt_o  = ma_grant;
      end
      S_BUSY_IF: begin
        if_rvalid_o = rsp_if && !kill_now;
      end
      S_BUSY_MA: begin
        ma_rvalid_o = rsp_ma;
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Store lane formatting
  // --------------------------------------------------------------------------
  always_comb begin
    ma_be          = 4'b1111;
    ma_wdata_lanes = ma_wdata_i;
    case (ma_size_i)
      SIZE_BYTE: begin
        ma_be          = 4'b0001 << ma_addr_i[1:0];
        ma_wdata_lanes = {4{ma_wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        ma_be          = ma_addr_i[1] ? 4'b1100 : 4'b0011;
        ma_wdata_lanes = {2{ma_wdata_i[15:0]}};
      end
      default: begin
        // Word, and the reserved size encoding, use the full word.
        ma_be          = 4'b1111;
        ma_wdata_lanes = ma_wdata_i;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request field mux
  // --------------------------------------------------------------------------
  always_comb begin
    if (ma_sel) begin
      mem_we_o    = mem_req_o && ma_we_i;
      mem_addr_o  = {ma_addr_i[31:2], 2'b00};
      mem_wdata_o = ma_wdata_lanes;
      mem_be_o    = ma_be;
    end else begin
      mem_we_o    = 1'b0;
      mem_addr_o  = {if_addr_i[31:2], 2'b00};
      mem_wdata_o = 32'h0000_0000;
      mem_be_o    = 4'b1111;
    end
  end

  assign if_rdata_o = mem_rdata_i;
  assign ma_rdata_o = mem_rdata_i;

  // --------------------------------------------------------------------------
  // MA streak counter and fetch kill tracking
  // --------------------------------------------------------------------------
  always_comb begin
    streak_d = streak_q;
    if (if_grant) begin
      streak_d = 4'd0;
    end else if (ma_grant) begin
      if (!if_req_i) begin
        streak_d = 4'd0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  always_comb begin
    kill_pend_d = kill_pend_q;
    if (rsp_if) begin
      kill_pend_d = 1'b0;
    end else if (if_kill_i && ((state_q == S_BUSY_IF) || if_grant)) begin
      kill_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      streak_q    <= 4'd0;
      kill_pend_q <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      kill_pend_q <= kill_pend_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a latency-
//            programmable memory model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_kill_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        ma_req_i, ma_we_i, ma_gnt_o, ma_rvalid_o;
  logic [31:0] ma_addr_i, ma_wdata_i, ma_rdata_o;
  logic [1:0]  ma_size_i;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_MA_STREAK(4)) dut (
    .clk(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ma_req_i(ma_req_i), .ma_we_i(ma_we_i), .ma_addr_i(ma_addr_i),
    .ma_wdata_i(ma_wdata_i), .ma_size_i(ma_size_i),
    .ma_gnt_o(ma_gnt_o), .ma_rvalid_o(ma_rvalid_o), .ma_rdata_o(ma_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic exp_rsp(input bit is_if, input logic [31:0] addr);
    rsp_t r;
    r.is_if = is_if;
    r.data  = mem_word({addr[31:2], 2'b00});
    sb.push_back(r);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Memory model: response arrives 'lat' cycles after the grant cycle.
  int          lat = 1;
  int          cnt = 0;
  logic        gnt_seen = 1'b0;
  logic [31:0] gnt_addr;
  logic [31:0] raddr = 32'h0;

  always @(negedge clk) begin
    gnt_seen = mem_req_o && mem_gnt_i;
    gnt_addr = mem_addr_o;
  end

  always @(posedge clk) begin
    #1;
    if (gnt_seen) begin
      cnt   = lat;
      raddr = gnt_addr;
    end else if (cnt > 0) begin
      cnt--;
    end
    mem_rvalid_i = (cnt == 1);
    mem_rdata_i  = (cnt == 1) ? mem_word(raddr) : 32'hDEAD_BEEF;
  end

  // Response monitor against the scoreboard.
  always @(negedge clk) begin
    if (if_rvalid_o || ma_rvalid_o) begin
      chk("rv_onehot", {31'd0, if_rvalid_o && ma_rvalid_o}, 32'd0);
      if (sb.size() == 0) begin
        chk("rv_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rv_owner", {31'd0, if_rvalid_o}, {31'd0, e.is_if});
        chk("rv_data", if_rvalid_o ? if_rdata_o : ma_rdata_o, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Store table: address, data, size, expected byte enables, expected lanes
  logic [31:0] st_addr [7] = '{32'h1003, 32'h1002, 32'h1000, 32'h1001, 32'h1004, 32'h1008, 32'h1006};
  logic [31:0] st_data [7] = '{32'h0000_00AB, 32'h0000_1234, 32'hFFFF_5678, 32'h1234_56CD,
                               32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0102_0304};
  logic [1:0]  st_size [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
  logic [3:0]  st_be   [7] = '{4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111, 4'b1111, 4'b1111};
  logic [31:0] st_wd   [7] = '{32'hABAB_ABAB, 32'h1234_1234, 32'h5678_5678, 32'hCDCD_CDCD,
                               32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0102_0304};

  initial begin
    rst_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    if_req_i = 1'b1; if_addr_i = 32'h0; if_kill_i = 1'b0;
    ma_req_i = 1'b1; ma_we_i = 1'b0; ma_addr_i = 32'h0; ma_wdata_i = 32'h0; ma_size_i = 2'b10;

    // Reset: no request or grant even with both requesters active
    sample();
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_if_gnt", {31'd0, if_gnt_o}, 32'd0);
    chk("rst_ma_gnt", {31'd0, ma_gnt_o}, 32'd0);
    chk("rst_if_rv", {31'd0, if_rvalid_o}, 32'd0);
    chk("rst_ma_rv", {31'd0, ma_rvalid_o}, 32'd0);
    next_cycle();
    rst_i = 1'b0; if_req_i = 1'b0; ma_req_i = 1'b0;
    sample();
    chk("idle_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_streak", {28'd0, dut.streak_q}, 32'd0);
    next_cycle();

    // IF only, latency 1
    if_req_i = 1'b1; if_addr_i = 32'h100;
    sample();
    chk("t1_gnt0", {31'd0, if_gnt_o}, 32'd1);
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_be", {28'd0, mem_be_o}, 32'hF);
    chk("t1_we", {31'd0, mem_we_o}, 32'd0);
    exp_rsp(1'b1, 32'h100);
    next_cycle();
    if_addr_i = 32'h107;
    sample();
    chk("t1_busy_req", {31'd0, mem_req_o}, 32'd0);
    chk("t1_busy_gnt", {31'd0, if_gnt_o}, 32'd0);
    chk("t1_rv", {31'd0, if_rvalid_o}, 32'd1);
    next_cycle();
    sample();
    chk("t1_gnt2", {31'd0, if_gnt_o}, 32'd1);
    chk("t1_addr2", mem_addr_o, 32'h104);
    exp_rsp(1'b1, 32'h104);
    next_cycle();
    if_req_i = 1'b0;
    sample();
    next_cycle();

    // Simultaneous IF and MA load: MA first, IF after MA response
    if_req_i = 1'b1; if_addr_i = 32'h200;
    ma_req_i = 1'b1; ma_we_i = 1'b0; ma_addr_i = 32'h2000; ma_size_i = 2'b10;
    sample();
    chk("t2_ma_gnt", {31'd0, ma_gnt_o}, 32'd1);
    chk("t2_if_gnt", {31'd0, if_gnt_o}, 32'd0);
    chk("t2_addr", mem_addr_o, 32'h2000);
    exp_rsp(1'b0, 32'h2000);
    next_cycle();
    ma_req_i = 1'b0;
    sample();
    chk("t2_busy_if_gnt", {31'd0, if_gnt_o}, 32'd0);
    chk("t2_ma_rv", {31'd0, ma_rvalid_o}, 32'd1);
    next_cycle();
    sample();
    chk("t2_if_gnt2", {31'd0, if_gnt_o}, 32'd1);
    chk("t2_addr2", mem_addr_o, 32'h200);
    exp_rsp(1'b1, 32'h200);
    next_cycle();
    if_req_i = 1'b0;
    sample();
    next_cycle();

    // Starvation bound: 4 MA grants, then IF
    if_req_i = 1'b1; if_addr_i = 32'h300;
    ma_req_i = 1'b1; ma_addr_i = 32'h3000;
    for (int g = 0; g < 5; g++) begin
      bit want_ma;
      want_ma = (g < 4);
      sample();
      chk($sformatf("t3_ma_gnt%0d", g), {31'd0, ma_gnt_o}, {31'd0, want_ma});
      chk($sformatf("t3_if_gnt%0d", g), {31'd0, if_gnt_o}, {31'd0, !want_ma});
      chk($sformatf("t3_addr%0d", g), mem_addr_o, want_ma ? ma_addr_i : 32'h300);
      if (want_ma) exp_rsp(1'b0, ma_addr_i);
      else         exp_rsp(1'b1, 32'h300);
      next_cycle();
      if (g == 4) begin
        if_req_i = 1'b0; ma_req_i = 1'b0;
      end else if (want_ma) begin
        ma_addr_i = ma_addr_i + 32'd4;
      end
      sample();
      chk($sformatf("t3_busy_req%0d", g), {31'd0, mem_req_o}, 32'd0);
      if (g == 4) chk("t3_streak_clr", {28'd0, dut.streak_q}, 32'd0);
      next_cycle();
    end

    // Store lane formatting
    for (int k = 0; k < 7; k++) begin
      ma_req_i = 1'b1; ma_we_i = 1'b1; ma_addr_i = st_addr[k];
      ma_wdata_i = st_data[k]; ma_size_i = st_size[k];
      sample();
      chk($sformatf("st%0d_gnt", k), {31'd0, ma_gnt_o}, 32'd1);
      chk($sformatf("st%0d_we", k), {31'd0, mem_we_o}, 32'd1);
      chk($sformatf("st%0d_be", k), {28'd0, mem_be_o}, {28'd0, st_be[k]});
      chk($sformatf("st%0d_wdata", k), mem_wdata_o, st_wd[k]);
      chk($sformatf("st%0d_addr", k), mem_addr_o, {st_addr[k][31:2], 2'b00});
      exp_rsp(1'b0, st_addr[k]);
      next_cycle();
      ma_req_i = 1'b0; ma_we_i = 1'b0;
      sample();
      next_cycle();
    end

    // Kill while BUSY_IF, latency 3: response discarded
    lat = 3;
    if_req_i = 1'b1; if_addr_i = 32'h400;
    sample();
    chk("t5_gnt", {31'd0, if_gnt_o}, 32'd1);
    next_cycle();
    if_req_i = 1'b0; if_kill_i = 1'b1;
    sample();
    chk("t5_rv_c1", {31'd0, if_rvalid_o}, 32'd0);
    next_cycle();
    if_kill_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h500; lat = 1;
    sample();
    chk("t5_busy_req", {31'd0, mem_req_o}, 32'd0);
    chk("t5_busy_gnt", {31'd0, if_gnt_o}, 32'd0);
    next_cycle();
    sample();
    chk("t5_mem_rv_seen", {31'd0, mem_rvalid_i}, 32'd1);
    chk("t5_rv_killed", {31'd0, if_rvalid_o}, 32'd0);
    chk("t5_rsp_req", {31'd0, mem_req_o}, 32'd0);
    next_cycle();
    sample();
    chk("t5_regnt", {31'd0, if_gnt_o}, 32'd1);
    exp_rsp(1'b1, 32'h500);
    next_cycle();
    if_req_i = 1'b0;
    sample();
    next_cycle();

    // Kill in the grant cycle
    if_req_i = 1'b1; if_addr_i = 32'h600; if_kill_i = 1'b1;
    sample();
    chk("t5b_gnt", {31'd0, if_gnt_o}, 32'd1);
    next_cycle();
    if_req_i = 1'b0; if_kill_i = 1'b0;
    sample();
    chk("t5b_rv_killed", {31'd0, if_rvalid_o}, 32'd0);
    next_cycle();

    // Kill in IDLE without grant has no effect
    if_kill_i = 1'b1;
    sample();
    next_cycle();
    if_kill_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h700;
    sample();
    chk("t5c_gnt", {31'd0, if_gnt_o}, 32'd1);
    exp_rsp(1'b1, 32'h700);
    next_cycle();
    if_req_i = 1'b0;
    sample();
    chk("t5c_rv", {31'd0, if_rvalid_o}, 32'd1);
    next_cycle();

    // Memory grant stall: request held, selection retried
    mem_gnt_i = 1'b0;
    ma_req_i = 1'b1; ma_we_i = 1'b0; ma_addr_i = 32'h2200; ma_size_i = 2'b10;
    sample();
    chk("t7_req", {31'd0, mem_req_o}, 32'd1);
    chk("t7_nogrant", {31'd0, ma_gnt_o}, 32'd0);
    next_cycle();
    mem_gnt_i = 1'b1;
    sample();
    chk("t7_gnt", {31'd0, ma_gnt_o}, 32'd1);
    exp_rsp(1'b0, 32'h2200);
    next_cycle();
    ma_req_i = 1'b0;
    sample();
    next_cycle();

    // Reset in BUSY_MA; stray response later ignored
    lat = 2;
    ma_req_i = 1'b1; ma_addr_i = 32'h2100;
    sample();
    chk("t6_gnt", {31'd0, ma_gnt_o}, 32'd1);
    next_cycle();
    ma_req_i = 1'b0; rst_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h800;
    sample();
    chk("t6_rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("t6_rst_gnt", {31'd0, if_gnt_o}, 32'd0);
    next_cycle();
    rst_i = 1'b0; lat = 1;
    sample();
    chk("t6_stray_present", {31'd0, mem_rvalid_i}, 32'd1);
    chk("t6_ma_rv", {31'd0, ma_rvalid_o}, 32'd0);
    chk("t6_if_gnt", {31'd0, if_gnt_o}, 32'd1);
    chk("t6_addr", mem_addr_o, 32'h800);
    exp_rsp(1'b1, 32'h800);
    next_cycle();
    if_req_i = 1'b0;
    sample();
    chk("t6_if_rv", {31'd0, if_rvalid_o}, 32'd1);
    next_cycle();
    sample();

    chk("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory port between instruction fetch (IF) and the memory-access stage (MA) of the 5-stage RISC-V pipeline. Enforces one outstanding transaction, gives MA priority with a starvation bound for IF, and routes each response to its owner. Generates byte enables and lane-replicated write data for MA stores. Discards responses for IF fetches killed by a branch/JALR redirect.

## Interface
Parameters:
- MAX_MA_STREAK, 4: maximum consecutive MA grants while IF is waiting; legal range 1–15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- if_req_i  in  1  IF fetch request; held until granted.
- if_addr_i  in  32  fetch address; bits [1:0] ignored.
- if_kill_i  in  1  redirect; invalidates the outstanding IF fetch, if any.
- if_gnt_o  out  1  IF request accepted this cycle.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  32  fetch data (= mem_rdata_i).
- ma_req_i  in  1  MA request; held until granted.
- ma_we_i  in  1  1 = store, 0 = load.
- ma_addr_i  in  32  byte address.
- ma_wdata_i  in  32  store data, right-aligned.
- ma_size_i  in  2  00 byte, 01 half, 10 word.
- ma_gnt_o  out  1  MA request accepted this cycle.
- ma_rvalid_o  out  1  load data valid, or store acknowledged.
- ma_rdata_o  out  32  raw memory word (= mem_rdata_i); extension is done by MA.
- mem_req_o  out  1  request to memory.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  32  word address {addr[31:2], 2'b00}.
- mem_wdata_o  out  32  lane-replicated write data.
- mem_be_o  out  4  byte enables.
- mem_gnt_i  in  1  memory accepts request this cycle.
- mem_rvalid_i  in  1  response for the outstanding request.
- mem_rdata_i  in  32  read data.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_MA. Reset value is IDLE.
- IDLE:
  - Select a requester combinationally and drive mem_req_o with its fields.
  - MA wins when both request, unless streak_cnt == MAX_MA_STREAK; IF then wins.
  - On mem_gnt_i, assert the winner's gnt, then go to BUSY_IF or BUSY_MA.
  - Without mem_gnt_i, stay in IDLE. The requester keeps its request up, and the selection is re-evaluated next cycle.
- BUSY_x:
  - mem_req_o = 0.
  - On mem_rvalid_i, pulse x_rvalid_o and return to IDLE.
- streak_cnt:
  - Width 4; reset value 0.
  - Increments on an MA grant while if_req_i = 1.
  - Clears on an IF grant, or on an MA grant while if_req_i = 0.
  - Saturates at MAX_MA_STREAK.
- Kill handling:
  - kill_pend is set when if_kill_i = 1 in BUSY_IF, or in the same cycle as if_gnt_o.
  - When the response arrives with kill_pend set: if_rvalid_o = 0, the response is consumed, and kill_pend clears.
  - if_kill_i in IDLE with no grant has no effect.
- Byte enables (MA), by size and addr[1:0]:
  - Byte: 0001 << addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
  - IF requests: mem_be_o = 1111, mem_we_o = 0.
- Write data (MA):
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Misalignment: alignment is checked by the decoder upstream. A misaligned half or word uses the table above unchanged, with no trap.
- ma_size_i = 11 is treated as word.
- Reset mid-transaction:
  - Returns to IDLE with streak_cnt = 0 and kill_pend = 0.
  - Any later mem_rvalid_i while in IDLE is ignored; no rvalid is forwarded.

## Timing
- Output values during and after reset:
  - mem_req_o, if_gnt_o, ma_gnt_o, if_rvalid_o, ma_rvalid_o are all 0 in the reset cycle.
  - mem_req_o, if_gnt_o and ma_gnt_o are 0 while rst_i = 1.
  - The rdata outputs follow mem_rdata_i.
- Request path is combinational: x_req_i → mem_req_o (same cycle); mem_gnt_i → x_gnt_o (same cycle).
- Response path is combinational: mem_rvalid_i → x_rvalid_o (same cycle).
- Minimum transaction length is 2 cycles: grant in cycle N, rvalid in cycle N+1 at the earliest.
- The next grant can occur no earlier than the cycle after rvalid. Peak throughput is one transaction per 2 cycles.
- Only one transaction is outstanding at a time. mem_req_o is never asserted in BUSY_x.
- A requester may change its fields or drop its request only after its gnt.

## Test plan
- IF only, memory latency 1: if_req_i = 1 at addr 0x100 → gnt in cycle 0, if_rvalid_o in cycle 1 carrying mem_rdata_i, next gnt in cycle 2.
- Simultaneous IF and MA load at 0x2000, MAX_MA_STREAK = 4 → MA granted first; IF granted after MA's rvalid.
- Continuous MA requests with IF waiting → exactly 4 MA grants, then 1 IF grant, then streak_cnt = 0.
- MA store byte: addr 0x1003, wdata 0x000000AB, size 00 → mem_be_o = 1000, mem_wdata_o = 0xABABABAB, mem_addr_o = 0x1000. Half store at 0x1002, wdata 0x1234 → be 1100, wdata 0x12341234.
- if_kill_i pulse in BUSY_IF with response latency 3 → if_rvalid_o stays 0; FSM back in IDLE after the response.
- rst_i asserted in BUSY_MA, then mem_rvalid_i arrives → ma_rvalid_o = 0, state IDLE, and a new IF request is granted immediately after reset releases.
